// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: sequential PC generation, single-outstanding InstCache
// requests, and a circular {pc, inst} FIFO presented to the Decoder with valid/ack.
module inst_fetch_queue #(
    parameter int          QUEUE_ADDR_WIDTH = 4,
    parameter logic [31:0] RESET_PC         = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        IC_req_valid,
    output logic [31:0] IC_req_addr,
    input  logic        IC_input_valid,
    input  logic [31:0] IC_inst,
    output logic        DC_valid,
    output logic [31:0] DC_inst,
    output logic [31:0] DC_pc,
    input  logic        DC_ack,
    input  logic        ROB_clear,
    input  logic [31:0] ROB_target_pc
);

    localparam int DEPTH = 1 << QUEUE_ADDR_WIDTH;
    localparam logic [QUEUE_ADDR_WIDTH:0] FULL_COUNT = {1'b1, {QUEUE_ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    state_t                    state;
    logic [31:0]               fetch_pc;
    logic [31:0]               req_addr_q;
    logic [QUEUE_ADDR_WIDTH-1:0] head;
    logic [QUEUE_ADDR_WIDTH-1:0] tail;
    logic [QUEUE_ADDR_WIDTH:0]   count;
    entry_t                    mem [DEPTH];

    logic full;
    logic issue;
    logic push;
    logic pop;

    // The request strobe is decided in the issuing S_IDLE cycle so a 1-cycle cache
    // can answer on the very next edge; reset forces it low regardless of state.
    always_comb begin
        full  = (count == FULL_COUNT);
        issue = rdy && !rst && (state == S_IDLE) && !ROB_clear && !full;
        push  = rdy && (state == S_WAIT) && IC_input_valid && !ROB_clear;
        pop   = rdy && DC_ack && DC_valid && !ROB_clear;
    end

    assign IC_req_valid = issue;
    assign IC_req_addr  = issue ? fetch_pc : req_addr_q;
    assign DC_valid     = (count != '0);
    assign DC_pc        = DC_valid ? mem[head].pc   : 32'h0;
    assign DC_inst      = DC_valid ? mem[head].inst : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            fetch_pc   <= RESET_PC;
            req_addr_q <= 32'h0;
        end else if (rdy) begin
            case (state)
                S_IDLE: begin
                    if (ROB_clear) begin
                        fetch_pc <= ROB_target_pc;
                    end else if (!full) begin
                        req_addr_q <= fetch_pc;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ROB_clear) begin
                        fetch_pc <= ROB_target_pc;
                        state    <= IC_input_valid ? S_IDLE : S_DROP;
                    end else if (IC_input_valid) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= S_IDLE;
                    end
                end
                S_DROP: begin
                    // The stale response still has to be absorbed before a new request.
                    if (ROB_clear) fetch_pc <= ROB_target_pc;
                    if (IC_input_valid) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (ROB_clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + QUEUE_ADDR_WIDTH'(1);
                if (pop)  head <= head + QUEUE_ADDR_WIDTH'(1);
                case ({push, pop})
                    2'b10:   count <= count + (QUEUE_ADDR_WIDTH+1)'(1);
                    2'b01:   count <= count - (QUEUE_ADDR_WIDTH+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // NOTE: storage has no reset; an entry is only observable once count covers it.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= '{pc: fetch_pc, inst: IC_inst};
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: randomized cache latency, Decoder ack and
// redirects, compared every cycle against a queue-based reference model.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        IC_req_valid;
    logic [31:0] IC_req_addr;
    logic        IC_input_valid;
    logic [31:0] IC_inst;
    logic        DC_valid;
    logic [31:0] DC_inst;
    logic [31:0] DC_pc;
    logic        DC_ack;
    logic        ROB_clear;
    logic [31:0] ROB_target_pc;

    inst_fetch_queue dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .IC_req_valid  (IC_req_valid),
        .IC_req_addr   (IC_req_addr),
        .IC_input_valid(IC_input_valid),
        .IC_inst       (IC_inst),
        .DC_valid      (DC_valid),
        .DC_inst       (DC_inst),
        .DC_pc         (DC_pc),
        .DC_ack        (DC_ack),
        .ROB_clear     (ROB_clear),
        .ROB_target_pc (ROB_target_pc)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the FIFO as a queue, the next fetch address, and whether a
    // request is outstanding (accepted) or abandoned (response to be thrown away).
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_drop;

    // Behavioural InstCache: answers lat cycles after the model's expected request.
    int resp_cnt = 0;
    int lat_min  = 1;
    int lat_max  = 1;

    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];

    task automatic tick(input bit r, input bit a, input bit c, input logic [31:0] t, input bit force_resp);
        bit          exp_req;
        bit          push;
        bit          pop;
        logic [63:0] head;
        @(negedge clk);
        rdy           = r;
        DC_ack        = a;
        ROB_clear     = c;
        ROB_target_pc = t;
        IC_inst       = $urandom;
        IC_input_valid = force_resp;
        if (r && resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) IC_input_valid = 1'b1;
        end
        #1;
        exp_req = r && !m_out && !m_drop && !c && (mq.size() < 16);
        head    = (mq.size() != 0) ? mq[0] : 64'h0;
        vectors++;
        if (IC_req_valid !== exp_req) begin
            miscompares++;
            $display("FAIL req_valid: got %b expected %b (t=%0t)", IC_req_valid, exp_req, $time);
        end
        if (exp_req) begin
            vectors++;
            if (IC_req_addr !== m_pc) begin
                miscompares++;
                $display("FAIL req_addr: got %h expected %h (t=%0t)", IC_req_addr, m_pc, $time);
            end
        end
        vectors++;
        if (DC_valid !== (mq.size() != 0)) begin
            miscompares++;
            $display("FAIL dc_valid: got %b expected %b (t=%0t)", DC_valid, mq.size() != 0, $time);
        end
        vectors++;
        if ({DC_pc, DC_inst} !== head) begin
            miscompares++;
            $display("FAIL dc_head: got %h/%h expected %h/%h (t=%0t)", DC_pc, DC_inst, head[63:32], head[31:0], $time);
        end
        if (IC_req_valid === 1'b1) req_log.push_back(IC_req_addr);
        if (r && a && !c && DC_valid === 1'b1) pop_log.push_back(DC_pc);
        if (r) begin
            push = m_out && IC_input_valid && !c;
            pop  = a && (mq.size() != 0) && !c;
            if (c) begin
                mq.delete();
                m_pc = t;
                if (m_out) begin
                    m_drop = !IC_input_valid;
                    m_out  = 1'b0;
                end else if (m_drop && IC_input_valid) begin
                    m_drop = 1'b0;
                end
            end else begin
                if (pop) void'(mq.pop_front());
                if (push) begin
                    mq.push_back({m_pc, IC_inst});
                    m_pc  = m_pc + 32'd4;
                    m_out = 1'b0;
                end
                if (m_drop && IC_input_valid) m_drop = 1'b0;
                if (exp_req) begin
                    m_out    = 1'b1;
                    resp_cnt = $urandom_range(lat_max, lat_min);
                end
            end
        end
    endtask

    task automatic do_reset(input bit keep_resp);
        @(negedge clk);
        rdy            = 1'b0;
        DC_ack         = 1'b0;
        ROB_clear      = 1'b0;
        ROB_target_pc  = 32'h0;
        IC_input_valid = 1'b0;
        rst            = 1'b1;
        #1;
        vectors++;
        if ({IC_req_valid, IC_req_addr, DC_valid, DC_inst, DC_pc} !== 98'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got req=%b addr=%h dcv=%b inst=%h pc=%h expected all zero",
                     IC_req_valid, IC_req_addr, DC_valid, DC_inst, DC_pc);
        end
        mq.delete();
        m_pc   = 32'h0;
        m_out  = 1'b0;
        m_drop = 1'b0;
        if (!keep_resp) resp_cnt = 0;
        req_log.delete();
        pop_log.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        tick(1, 0, 0, 0, 0);
    endtask

    task automatic test_sequential();
        logic [31:0] want [3] = '{32'h0, 32'h4, 32'h8};
        do_reset(1'b0);
        lat_min = 1; lat_max = 1;
        repeat (12) tick(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (req_log.size() <= i || req_log[i] !== want[i]) begin
                miscompares++;
                $display("FAIL seq_req[%0d]: got %h expected %h", i, (req_log.size() > i) ? req_log[i] : 32'hx, want[i]);
            end
            vectors++;
            if (pop_log.size() <= i || pop_log[i] !== want[i]) begin
                miscompares++;
                $display("FAIL seq_dc_pc[%0d]: got %h expected %h", i, (pop_log.size() > i) ? pop_log[i] : 32'hx, want[i]);
            end
        end
    endtask

    task automatic test_fill();
        do_reset(1'b0);
        lat_min = 1; lat_max = 3;
        repeat (100) tick(1, 0, 0, 0, 0);
        vectors++;
        if (req_log.size() != 16) begin
            miscompares++;
            $display("FAIL fill_requests: got %0d expected 16", req_log.size());
        end
        req_log.delete();
        tick(1, 1, 0, 0, 0);
        repeat (20) tick(1, 0, 0, 0, 0);
        vectors++;
        if (req_log.size() != 1 || req_log[0] !== 32'h40) begin
            miscompares++;
            $display("FAIL fill_one_ack: got %0d requests expected 1 at 00000040", req_log.size());
        end
    endtask

    task automatic test_clear_wait();
        do_reset(1'b0);
        lat_min = 3; lat_max = 3;
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 1, 32'h100, 0);
        req_log.delete();
        repeat (6) tick(1, 1, 0, 0, 0);
        vectors++;
        if (req_log.size() == 0 || req_log[0] !== 32'h100) begin
            miscompares++;
            $display("FAIL clear_wait_redirect: got %h expected 00000100", (req_log.size() != 0) ? req_log[0] : 32'hx);
        end
    endtask

    task automatic test_clear_coincident();
        int guard = 0;
        do_reset(1'b0);
        lat_min = 1; lat_max = 1;
        while (!(mq.size() == 3 && resp_cnt == 1) && guard < 40) begin
            tick(1, 0, 0, 0, 0);
            guard++;
        end
        vectors++;
        if (guard >= 40) begin
            miscompares++;
            $display("FAIL clear_coincident_setup: got %0d cycles expected < 40", guard);
        end
        tick(1, 1, 1, 32'h200, 0);
        req_log.delete();
        repeat (4) tick(1, 0, 0, 0, 0);
        vectors++;
        if (req_log.size() == 0 || req_log[0] !== 32'h200) begin
            miscompares++;
            $display("FAIL clear_coincident_redirect: got %h expected 00000200", (req_log.size() != 0) ? req_log[0] : 32'hx);
        end
    endtask

    task automatic test_random_wrap();
        do_reset(1'b0);
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            bit r = ($urandom_range(0, 9) != 0);
            bit a = (i % 600 < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            bit c = ($urandom_range(0, 99) == 0);
            tick(r, a, c, $urandom & 32'hFFFF_FFFC, 0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        lat_min = 3; lat_max = 3;
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        do_reset(1'b0);
        lat_min = 2; lat_max = 2;
        // The stale response lands in the first post-reset cycle.
        tick(1, 0, 0, 0, 1);
        repeat (5) tick(1, 0, 0, 0, 0);
        vectors++;
        if (req_log.size() == 0 || req_log[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_first_req: got %h expected 00000000", (req_log.size() != 0) ? req_log[0] : 32'hx);
        end
    endtask

    initial begin
        rst            = 1'b1;
        rdy            = 1'b0;
        DC_ack         = 1'b0;
        ROB_clear      = 1'b0;
        ROB_target_pc  = 32'h0;
        IC_input_valid = 1'b0;
        IC_inst        = 32'h0;
        test_reset();
        test_sequential();
        test_fill();
        test_clear_wait();
        test_clear_coincident();
        test_random_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
